vga_fetch_sched: RTL and testbench
==================================

Name: vga_fetch_sched

Overview:
- Schedules AXI4 read-address bursts that fetch framebuffer pixels for the VGA line FIFO inside axi4_vga.
- Walks a frame line by line from a base address with a programmable stride, which the APB4 register block configures.
- Issues a burst only when the line FIFO has room for every beat already requested plus the new burst.
- Splits bursts at 4 KB boundaries and reports frame completion.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- BURST_LEN, 16, maximum beats per burst (1..256).
- FIFO_DEPTH, 512, line FIFO depth in 32-bit beats (power of two).
- CNT_WIDTH, 12, width of the line-length and line-count fields.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- en_i  in  1  fetch enable, from the control register.
- frame_start_i  in  1  one-cycle pulse at the start of the vertical blanking period.
- base_addr_i  in  ADDR_WIDTH  frame base byte address; bits[1:0] are ignored.
- stride_i  in  ADDR_WIDTH  byte offset between consecutive lines; bits[1:0] are ignored.
- line_beats_i  in  CNT_WIDTH  32-bit beats per line.
- num_lines_i  in  CNT_WIDTH  lines per frame.
- fifo_level_i  in  $clog2(FIFO_DEPTH)+1  current FIFO occupancy in beats.
- ar_valid_o  out  1  AXI AR valid.
- ar_ready_i  in  1  AXI AR ready.
- ar_addr_o  out  ADDR_WIDTH  burst start address.
- ar_len_o  out  8  AXI burst length (beats-1).
- r_beat_i  in  1  one R-channel beat accepted into the FIFO (rvalid & rready).
- busy_o  out  1  high whenever the state is not IDLE.
- frame_done_o  out  1  one-cycle pulse when the frame is fully fetched.
- overrun_o  out  1  one-cycle pulse when frame_start_i is dropped while busy.

Behaviour:
- Reset: state IDLE; every output 0; all counters and address registers 0.
- Configuration inputs are sampled only when frame_start_i is accepted in IDLE; later changes have no effect until the next frame.
- Beat = 4 bytes; every address increment is beats*4.
- States: IDLE, LOAD, REQ, WAIT, DRAIN.
- IDLE, on frame_start_i & en_i:
  - If line_beats_i==0 or num_lines_i==0: frame_done_o pulses the next cycle; state stays IDLE.
  - Otherwise: latch cur_addr=base, line_addr=base, rem=line_beats, line_cnt=0; go LOAD.
- LOAD: compute blen = min(BURST_LEN, rem, (4096-cur_addr[11:0])/4). Go REQ if space_ok, else WAIT.
  - space_ok = fifo_level_i + outstanding + blen <= FIFO_DEPTH.
  - Intermediate widths are wide enough that the sum cannot overflow.
- WAIT: re-evaluate space_ok each cycle; go REQ when it holds.
- REQ: ar_valid_o=1, ar_addr_o=cur_addr, ar_len_o=blen-1. All three are registered and stay stable until ar_ready_i.
- On AR handshake:
  - outstanding += blen; rem -= blen; cur_addr += blen*4.
  - If rem!=0: go LOAD.
  - Else if line_cnt==num_lines-1: go DRAIN.
  - Else: line_cnt++; line_addr += stride; cur_addr = line_addr+stride; rem = line_beats; go LOAD.
- Latency: an accepted frame_start at cycle N with space available gives ar_valid_o=1 at N+2.
- outstanding:
  - Decrements on r_beat_i.
  - A simultaneous handshake and r_beat_i in the same cycle nets to +blen-1.
  - r_beat_i while outstanding==0 is ignored; the counter saturates at 0.
- en_i deasserted:
  - In LOAD or WAIT: go DRAIN immediately.
  - In REQ: hold ar_valid_o until the handshake completes, then go DRAIN.
  - AR valid is never withdrawn before handshake.
- DRAIN: when outstanding==0, pulse frame_done_o and go IDLE.
- frame_start_i in any state other than IDLE: ignored, and overrun_o pulses in the same cycle. A frame_start_i ignored in IDLE because en_i=0 does not pulse overrun_o.
- Address wraps modulo 2^ADDR_WIDTH; no error is raised on wrap.
- busy_o = (state != IDLE).

Test Plan:
- Basic line:
  - Stimulus: base=0x1000, line_beats=40, num_lines=1, BURST_LEN=16, fifo_level=0, ar_ready tied 1, R beats returned.
  - Required: AR bursts 0x1000/len15, 0x1040/len15, 0x1080/len7, then frame_done_o after the 40th r_beat.
- 4 KB split:
  - Stimulus: base=0x0FF0, line_beats=16.
  - Required: bursts 0x0FF0/len3 then 0x1000/len11; no burst crosses 0x1000.
- Stride and line walk:
  - Stimulus: base=0x2000, stride=0x400, line_beats=8, num_lines=3.
  - Required: bursts at 0x2000, 0x2400, 0x2800, each len7; frame_done once.
- FIFO back-pressure:
  - Stimulus: fifo_level=500, FIFO_DEPTH=512, BURST_LEN=16.
  - Required: ar_valid_o stays 0 (WAIT) until fifo_level+outstanding<=496, then the burst issues.
- Handshake hold and disable:
  - Stimulus: ar_ready=0 for 5 cycles, en_i dropped in cycle 2.
  - Required: ar_valid/addr/len remain stable until ready; no further AR after it; frame_done_o once outstanding reaches 0.
- Overrun, zero config and reset:
  - Stimulus: frame_start while busy; num_lines=0; rst_i mid-burst.
  - Required: overrun_o pulses for the busy frame_start; immediate frame_done_o with no AR for num_lines=0; all outputs 0 and state IDLE the cycle after rst_i.

Source files
------------

// File: rtl/vga_fetch_sched.sv
// vga_fetch_sched: walks a framebuffer line by line and issues AXI4 read-address
// bursts for the VGA line FIFO. Bursts are clipped to BURST_LEN, the rest of the
// line and the current 4 KB page. A burst is only issued while the FIFO can hold
// every beat already in flight plus the new burst.
module vga_fetch_sched #(
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          frame_start_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic [ADDR_WIDTH-1:0]         stride_i,
  input  logic [CNT_WIDTH-1:0]          line_beats_i,
  input  logic [CNT_WIDTH-1:0]          num_lines_i,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_level_i,
  output logic                          ar_valid_o,
  input  logic                          ar_ready_i,
  output logic [ADDR_WIDTH-1:0]         ar_addr_o,
  output logic [7:0]                    ar_len_o,
  input  logic                          r_beat_i,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          overrun_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, DRAIN} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] cur_addr, line_addr, stride_r;
  logic [CNT_WIDTH-1:0]  line_beats_r, num_lines_r, rem, line_cnt, rem_next;
  logic [LVL_W-1:0]      outstanding, out_next;
  logic                  abort;
  logic                  ar_valid_r;
  logic [ADDR_WIDTH-1:0] ar_addr_r;
  logic [7:0]            ar_len_r;
  logic                  frame_done_r;

  logic [10:0]           page_beats;
  logic [8:0]            blen;
  logic                  space_ok, handshake, zero_cfg, line_last;
  logic                  start_frame, done_set, next_line;

  assign handshake = (state == REQ) && ar_valid_r && ar_ready_i;
  assign zero_cfg  = (line_beats_i == '0) || (num_lines_i == '0);
  assign rem_next  = rem - CNT_WIDTH'(blen);
  assign line_last = (line_cnt == (num_lines_r - CNT_WIDTH'(1)));

  // Burst length is the smallest of the burst cap, the rest of the line and the beats left in the 4 KB page; space check uses wide sums.
  always_comb begin
    page_beats = 11'd1024 - {1'b0, cur_addr[11:2]};
    blen = 9'(BURST_LEN);
    if (32'(rem) < 32'(blen)) blen = 9'(rem);
    if (32'(page_beats) < 32'(blen)) blen = 9'(page_beats);
    space_ok = (32'(fifo_level_i) + 32'(outstanding) + 32'(blen)) <= 32'(FIFO_DEPTH);
  end

  // In-flight beat counter: grows by the burst on handshake, shrinks per returned beat, never below zero.
  always_comb begin
    out_next = outstanding;
    if (handshake) out_next = out_next + LVL_W'(blen);
    if (r_beat_i && (outstanding != '0)) out_next = out_next - LVL_W'(1);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic plus the one-cycle strobes that steer the datapath.
  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    done_set    = 1'b0;
    next_line   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start_i && en_i) begin
          if (zero_cfg) begin
            done_set = 1'b1;
          end else begin
            start_frame = 1'b1;
            state_n     = LOAD;
          end
        end
      end
      LOAD, WAIT: begin
        if (!en_i)         state_n = DRAIN;
        else if (space_ok) state_n = REQ;
        else               state_n = WAIT;
      end
      REQ: begin
        if (handshake) begin
          if (abort || !en_i)      state_n = DRAIN;
          else if (rem_next != '0) state_n = LOAD;
          else if (line_last)      state_n = DRAIN;
          else begin
            next_line = 1'b1;
            state_n   = LOAD;
          end
        end
      end
      DRAIN: begin
        if (outstanding == '0) begin
          done_set = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: frame configuration latch, address walk, counters and the registered AR channel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_addr     <= '0;
      line_addr    <= '0;
      stride_r     <= '0;
      line_beats_r <= '0;
      num_lines_r  <= '0;
      rem          <= '0;
      line_cnt     <= '0;
      outstanding  <= '0;
      abort        <= 1'b0;
      ar_valid_r   <= 1'b0;
      ar_addr_r    <= '0;
      ar_len_r     <= '0;
      frame_done_r <= 1'b0;
    end else begin
      if (start_frame) begin
        cur_addr     <= base_addr_i & ADDR_MASK;
        line_addr    <= base_addr_i & ADDR_MASK;
        stride_r     <= stride_i & ADDR_MASK;
        line_beats_r <= line_beats_i;
        num_lines_r  <= num_lines_i;
        rem          <= line_beats_i;
        line_cnt     <= '0;
      end else if (handshake) begin
        if (next_line) begin
          line_cnt  <= line_cnt + CNT_WIDTH'(1);
          line_addr <= line_addr + stride_r;
          cur_addr  <= line_addr + stride_r;
          rem       <= line_beats_r;
        end else begin
          rem      <= rem_next;
          cur_addr <= cur_addr + ADDR_WIDTH'({blen, 2'b00});
        end
      end
      outstanding <= out_next;
      abort       <= (state == REQ) && (abort || !en_i);
      if ((state_n == REQ) && (state != REQ)) begin
        ar_valid_r <= 1'b1;
        ar_addr_r  <= cur_addr;
        ar_len_r   <= 8'(blen - 9'd1);
      end else if (handshake) begin
        ar_valid_r <= 1'b0;
      end
      frame_done_r <= done_set;
    end
  end

  assign ar_valid_o   = ar_valid_r;
  assign ar_addr_o    = ar_addr_r;
  assign ar_len_o     = ar_len_r;
  assign frame_done_o = frame_done_r;
  assign busy_o       = (state != IDLE);
  assign overrun_o    = frame_start_i && (state != IDLE);

endmodule

// File: tb/tb_vga_fetch_sched.sv
// tb_vga_fetch_sched: directed bench with an AR scoreboard and an R-beat responder.
module tb_vga_fetch_sched;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic        clk = 1'b0;
  logic        rst, en, frame_start, ar_ready;
  logic        r_beat = 1'b0;
  logic [31:0] base, stride;
  logic [11:0] line_beats, num_lines;
  logic [9:0]  fifo_level;
  logic        ar_valid, busy, frame_done, overrun;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;

  int  vectors     = 0;
  int  miscompares = 0;
  int  done_cnt    = 0;
  int  beats_given = 0;
  int  pending     = 0;
  ar_t exp_q[$];

  vga_fetch_sched #(
    .ADDR_WIDTH(32), .BURST_LEN(16), .FIFO_DEPTH(512), .CNT_WIDTH(12)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .frame_start_i(frame_start),
    .base_addr_i(base), .stride_i(stride), .line_beats_i(line_beats),
    .num_lines_i(num_lines), .fifo_level_i(fifo_level),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
    .ar_len_o(ar_len), .r_beat_i(r_beat), .busy_o(busy),
    .frame_done_o(frame_done), .overrun_o(overrun)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case the design wedges somewhere the directed waits do not cover.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus model: returns one R beat per cycle for accepted bursts and checks each AR handshake against the scoreboard.
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (rst) pending = 0;
    r_beat = (pending > 0);
    if (r_beat) begin
      pending--;
      beats_given++;
    end
    if (!rst && (ar_valid === 1'b1) && ar_ready) begin
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("[TB] FAIL ar_unexpected: observed burst at 0x%0h len %0d, expected none", ar_addr, ar_len);
      end
      if (exp_q.size() > 0) begin
        ar_t e;
        e = exp_q.pop_front();
        checkOutput("ar_addr", ar_addr, e.addr);
        checkOutput("ar_len", {24'd0, ar_len}, {24'd0, e.len});
      end
      pending += int'(ar_len) + 1;
    end
  end

  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] s, input int lb, input int nl);
    base        = b;
    stride      = s;
    line_beats  = 12'(lb);
    num_lines   = 12'(nl);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic expectBurst(input logic [31:0] a, input logic [7:0] l);
    ar_t e;
    e.addr = a;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  task automatic waitArValid(input string tag, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ar_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic finishFrame(input string tag, input int d0, input int b0, input int beats);
    logic seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    checkOutput({tag, "_beats"}, 32'(beats_given - b0), 32'(beats));
    checkOutput({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d0, b0;
    rst = 1'b1; en = 1'b0; frame_start = 1'b0; ar_ready = 1'b1;
    base = '0; stride = '0; line_beats = '0; num_lines = '0; fifo_level = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ar_valid", {31'd0, ar_valid}, 32'd0);
    checkOutput("rst_ar_addr", ar_addr, 32'd0);
    checkOutput("rst_ar_len", {24'd0, ar_len}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b1;

    $display("[TB] basic line");
    d0 = done_cnt; b0 = beats_given;
    expectBurst(32'h1000, 8'd15);
    expectBurst(32'h1040, 8'd15);
    expectBurst(32'h1080, 8'd7);
    applyStimulus(32'h1000, 32'h0, 40, 1);
    @(negedge clk);
    checkOutput("latency_n1_valid", {31'd0, ar_valid}, 32'd0);
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("latency_n2_valid", {31'd0, ar_valid}, 32'd1);
    finishFrame("basic", d0, b0, 40);

    $display("[TB] 4 KB split");
    d0 = done_cnt; b0 = beats_given;
    expectBurst(32'h0FF0, 8'd3);
    expectBurst(32'h1000, 8'd11);
    applyStimulus(32'h0FF0, 32'h0, 16, 1);
    finishFrame("split", d0, b0, 16);

    $display("[TB] stride and line walk");
    d0 = done_cnt; b0 = beats_given;
    expectBurst(32'h2000, 8'd7);
    expectBurst(32'h2400, 8'd7);
    expectBurst(32'h2800, 8'd7);
    applyStimulus(32'h2000, 32'h400, 8, 3);
    finishFrame("stride", d0, b0, 24);

    $display("[TB] fifo back-pressure");
    d0 = done_cnt; b0 = beats_given;
    fifo_level = 10'd500;
    expectBurst(32'h3000, 8'd15);
    applyStimulus(32'h3000, 32'h0, 16, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("bp_wait_valid", {31'd0, ar_valid}, 32'd0);
    end
    checkOutput("bp_wait_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    fifo_level = 10'd497;
    @(posedge clk); #1;
    fifo_level = 10'd496;
    @(negedge clk);
    checkOutput("bp_497_valid", {31'd0, ar_valid}, 32'd0);
    @(negedge clk);
    checkOutput("bp_496_valid", {31'd0, ar_valid}, 32'd1);
    @(posedge clk); #1;
    fifo_level = 10'd0;
    finishFrame("bp", d0, b0, 16);

    $display("[TB] handshake hold and disable");
    d0 = done_cnt; b0 = beats_given;
    ar_ready = 1'b0;
    expectBurst(32'h4000, 8'd15);
    applyStimulus(32'h4000, 32'h0, 64, 1);
    waitArValid("hold_valid_seen", 10);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", {31'd0, ar_valid}, 32'd1);
      checkOutput("hold_addr", ar_addr, 32'h4000);
      checkOutput("hold_len", {24'd0, ar_len}, 32'd15);
      @(posedge clk); #1;
      if (i == 1) en = 1'b0;
      if (i == 4) ar_ready = 1'b1;
      @(negedge clk);
    end
    finishFrame("hold", d0, b0, 16);
    en = 1'b1;

    $display("[TB] overrun");
    d0 = done_cnt; b0 = beats_given;
    expectBurst(32'h5000, 8'd15);
    expectBurst(32'h5040, 8'd15);
    applyStimulus(32'h5000, 32'h0, 32, 1);
    base        = 32'h9000;
    frame_start = 1'b1;
    @(negedge clk);
    checkOutput("overrun_busy", {31'd0, overrun}, 32'd1);
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    checkOutput("overrun_clear", {31'd0, overrun}, 32'd0);
    finishFrame("overrun", d0, b0, 32);

    en          = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    checkOutput("overrun_idle_disabled", {31'd0, overrun}, 32'd0);
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    checkOutput("disabled_start_busy", {31'd0, busy}, 32'd0);
    checkOutput("disabled_start_done", {31'd0, frame_done}, 32'd0);
    @(posedge clk); #1;
    en = 1'b1;

    $display("[TB] zero configuration");
    d0 = done_cnt;
    applyStimulus(32'h7000, 32'h0, 8, 0);
    @(negedge clk);
    checkOutput("zero_lines_done", {31'd0, frame_done}, 32'd1);
    checkOutput("zero_lines_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("zero_lines_done_pulse", {31'd0, frame_done}, 32'd0);
    @(posedge clk); #1;
    applyStimulus(32'h7000, 32'h0, 0, 4);
    @(negedge clk);
    checkOutput("zero_beats_done", {31'd0, frame_done}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("zero_cfg_done_count", 32'(done_cnt - d0), 32'd2);
    checkOutput("zero_cfg_ar_valid", {31'd0, ar_valid}, 32'd0);

    $display("[TB] reset mid-burst");
    d0 = done_cnt;
    ar_ready = 1'b0;
    applyStimulus(32'h6000, 32'h0, 32, 1);
    waitArValid("rst_mid_valid_seen", 10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    ar_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_ar_valid", {31'd0, ar_valid}, 32'd0);
    checkOutput("rst_mid_ar_addr", ar_addr, 32'd0);
    checkOutput("rst_mid_ar_len", {24'd0, ar_len}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_frame_done", {31'd0, frame_done}, 32'd0);
    checkOutput("rst_mid_overrun", {31'd0, overrun}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_mid_stays_idle", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
